step_input_conditioner: RTL and testbench
=========================================

// Module: step_input_conditioner
// PURPOSE
//  Front end for the i1..i4 pattern-sequence recogniser. Synchronises raw
//  switch/pin inputs, debounces them as one vector and turns each settled
//  pattern change into a single "step" event. Events are queued in a small
//  FIFO and handed downstream over valid/ready, so the recogniser sees one
//  clean sample per step, never a glitch or a repeated level.
// PARAMETERS
//  WIDTH        4   raw input vector width (bit0=i1, bit1=i2, bit2=i3, bit3=i4)
//  SYNC_STAGES  2   synchroniser flops per bit (>=2)
//  DEBOUNCE     8   consecutive equal synced cycles required to accept (>=1)
//  DEPTH        4   event FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              reset, synchronous, active-high
//  raw_in       in   WIDTH          asynchronous raw inputs
//  step_valid   out  1              FIFO head holds an event
//  step_ready   in   1              downstream accepts head this cycle
//  step_data    out  WIDTH          pattern of head event
//  stable_data  out  WIDTH          last accepted debounced pattern
//  fill         out  $clog2(DEPTH)+1  FIFO occupancy
//  overrun      out  1              sticky: event dropped because FIFO full
//  clr_overrun  in   1              clears overrun (reset has priority)
// BEHAVIOUR
//  Reset: sync chain, candidate, counter, stable_data = 0; FIFO empty; fill=0;
//   step_valid=0; step_data=0; overrun=0; FSM -> IDLE. Reset mid-operation
//   discards queued events and any settle in progress.
//  Sync: raw_in passes SYNC_STAGES flops -> sync_q. No logic before last flop.
//  FSM (debounce), evaluated every cycle on sync_q:
//   IDLE:   sync_q==stable_data -> stay. Else candidate<=sync_q, cnt<=1 -> SETTLE.
//   SETTLE: sync_q!=candidate -> candidate<=sync_q, cnt<=1 (restart; if
//           sync_q==stable_data -> IDLE instead, no event).
//           sync_q==candidate: cnt==DEBOUNCE -> COMMIT; else cnt<=cnt+1.
//   COMMIT: stable_data<=candidate; push candidate to FIFO; -> IDLE (1 cycle).
//  Latency: raw_in change held steady -> step_valid high exactly
//   SYNC_STAGES+DEBOUNCE+1 cycles later when FIFO was empty (11 with defaults).
//  Pulse shorter than DEBOUNCE synced cycles: no event, stable_data unchanged.
//  Returning to the old stable value never creates an event; a bounce
//   A->B->A settles with no output.
//  FIFO: step_valid = (fill!=0); step_data = head entry (0 when empty).
//   Pop on step_valid&&step_ready. Push on COMMIT.
//   Push+pop same cycle: fill unchanged, both occur, also when full.
//   Push when full without pop: event dropped, stable_data still updates,
//   overrun<=1. overrun cleared only by reset or clr_overrun (set wins over
//   clr on the same cycle).
//  Pointers wrap modulo DEPTH; fill saturates logically at DEPTH (never wraps).
//  step_ready while empty: ignored, no state change.
// TESTING
//  1 Reset, raw_in=4'b0100 held -> step_valid rises cycle 11 after reset
//    release, step_data=4'b0100, stable_data=4'b0100, fill=1.
//  2 Glitch: raw_in 0000->0001 for 5 cycles ->0000 -> no step_valid ever,
//    stable_data=0000.
//  3 Bounce: 0000->1001 toggling every 3 cycles x4, then held 1001 ->
//    exactly one event 1001, 11 cycles after final transition.
//  4 step_ready=0, five distinct settled patterns -> fill=4, overrun=1, head
//    = first pattern, fifth lost; then ready=1 pops 4 in order, valid drops.
//  5 Full FIFO, COMMIT coincides with pop -> fill stays 4, overrun stays 0,
//    new pattern at tail.
//  6 Reset asserted mid-SETTLE with fill=2 -> next cycle fill=0,
//    step_valid=0, overrun=0, stable_data=0; no event for abandoned pattern.

Source files
------------

// File: rtl/step_input_conditioner_if.sv
// Step event handshake between the input conditioner and the pattern recogniser.
// The conditioner is the master: it presents the head event and sees the consumer's ready.
interface step_input_conditioner_if #(
    parameter int unsigned WIDTH = 4
);
    logic             step_valid;
    logic             step_ready;
    logic [WIDTH-1:0] step_data;

    modport master (
        output step_valid,
        output step_data,
        input  step_ready
    );

    modport slave (
        input  step_valid,
        input  step_data,
        output step_ready
    );
endinterface

// File: rtl/step_input_conditioner.sv
// Synchronise, debounce and queue settled raw input patterns as single step events
// for the i1..i4 pattern-sequence recogniser.
module step_input_conditioner #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 8,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           raw_in,
    step_input_conditioner_if.master   step_if,
    output logic [WIDTH-1:0]           stable_data,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overrun,
    input  logic                       clr_overrun
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMMIT
    } state_t;

    logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]  w_sync_q;

    state_t            r_state;
    logic [WIDTH-1:0]  r_cand;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_stable;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic              r_overrun;

    logic              w_commit;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Pure flop chain; nothing combinational ahead of the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= raw_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // The settled pattern is published and queued on the edge that leaves SETTLE;
    // COMMIT is a one-cycle holdoff before sampling resumes in IDLE.
    assign w_commit = (r_state == ST_SETTLE) && (w_sync_q == r_cand)
                      && (r_cnt == CNT_W'(DEBOUNCE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sync_q != r_stable) begin
                        r_cand  <= w_sync_q;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_sync_q != r_cand) begin
                        if (w_sync_q == r_stable) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cand <= w_sync_q;
                            r_cnt  <= CNT_W'(1);
                        end
                    end else if (w_commit) begin
                        r_stable <= r_cand;
                        r_state  <= ST_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == FILL_W'(DEPTH));
    assign w_pop   = !w_empty && step_if.step_ready;
    // A full FIFO still accepts the new event when the head leaves on the same edge.
    assign w_push  = w_commit && (!w_full || w_pop);
    assign w_drop  = w_commit && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FILL_W'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - FILL_W'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign step_if.step_valid = !w_empty;
    assign step_if.step_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign stable_data        = r_stable;
    assign fill               = r_fill;
    assign overrun            = r_overrun;

endmodule

// File: tb/tb_step_input_conditioner.sv
// Directed bench for step_input_conditioner: an event-level reference model is
// compared every cycle, and hand-derived literals pin key timing points.
module tb_step_input_conditioner;

    localparam int unsigned W  = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 8;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  raw_in = '0;
    logic          step_ready = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [W-1:0]  stable_data;
    logic [2:0]    fill;
    logic          overrun;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    step_input_conditioner_if #(.WIDTH(W)) u_if ();
    assign u_if.step_ready = step_ready;

    step_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE(DB), .DEPTH(DP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .step_if(u_if.master),
        .stable_data(stable_data),
        .fill(fill),
        .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: raw samples in flight, recent eligible synced samples,
    // committed pattern and the event queue.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_fifo[$];
    logic [W-1:0] m_stable;
    bit           m_skip;
    bit           m_ovr;
    logic [W-1:0] m_s;
    bit           m_ev;
    bit           m_same;
    bit           m_pop;

    always @(posedge clk) begin
        if (reset) begin
            m_pipe = {};
            for (int i = 0; i < int'(SS); i++) m_pipe.push_back('0);
            m_hist   = {};
            m_fifo   = {};
            m_stable = '0;
            m_skip   = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            m_s = m_pipe.pop_front();
            m_pipe.push_back(raw_in);
            m_ev = 1'b0;
            if (m_skip) begin
                m_skip = 1'b0;
            end else begin
                m_hist.push_back(m_s);
                if (m_hist.size() > int'(DB) + 1) void'(m_hist.pop_front());
                m_same = (m_hist.size() == int'(DB) + 1);
                foreach (m_hist[i]) if (m_hist[i] != m_s) m_same = 1'b0;
                if (m_same && (m_s != m_stable)) begin
                    m_ev     = 1'b1;
                    m_stable = m_s;
                    m_hist   = {};
                    m_skip   = 1'b1;
                end
            end
            m_pop = (m_fifo.size() > 0) && step_ready;
            if (clr_overrun) m_ovr = 1'b0;
            if (m_pop) void'(m_fifo.pop_front());
            if (m_ev) begin
                if (m_fifo.size() < int'(DP)) m_fifo.push_back(m_s);
                else m_ovr = 1'b1;
            end
        end
    end

    logic [W-1:0] exp_data;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_data = (m_fifo.size() > 0) ? m_fifo[0] : '0;
            check("model step_valid", 32'(u_if.step_valid), 32'(m_fifo.size() != 0));
            check("model step_data", 32'(u_if.step_data), 32'(exp_data));
            check("model stable_data", 32'(stable_data), 32'(m_stable));
            check("model fill", 32'(fill), 32'(m_fifo.size()));
            check("model overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [W-1:0] raw);
        @(negedge clk);
        reset       = 1'b1;
        raw_in      = raw;
        step_ready  = 1'b0;
        clr_overrun = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic settle(input logic [W-1:0] pat);
        raw_in = pat;
        tick(14);
    endtask

    logic [W-1:0] pats4 [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    logic [W-1:0] exp5  [4] = '{4'b0111, 4'b1000, 4'b1010, 4'b1011};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: latency from reset release with a held pattern
        do_reset(4'b0100);
        chk_en = 1'b1;
        check("t1 reset fill", 32'(fill), 32'd0);
        check("t1 reset stable", 32'(stable_data), 32'd0);
        tick(10);
        check("t1 valid before 11", 32'(u_if.step_valid), 32'd0);
        tick(1);
        check("t1 valid at 11", 32'(u_if.step_valid), 32'd1);
        check("t1 data", 32'(u_if.step_data), 32'h4);
        check("t1 stable", 32'(stable_data), 32'h4);
        check("t1 fill", 32'(fill), 32'd1);

        // 2: short glitch produces nothing
        do_reset(4'b0000);
        raw_in = 4'b0001;
        tick(5);
        raw_in = 4'b0000;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            check("t2 no valid", 32'(u_if.step_valid), 32'd0);
        end
        check("t2 stable", 32'(stable_data), 32'd0);

        // 3: bounce then hold gives one event
        do_reset(4'b0000);
        for (int i = 0; i < 2; i++) begin
            raw_in = 4'b1001; tick(3);
            raw_in = 4'b0000; tick(3);
        end
        raw_in = 4'b1001;
        tick(10);
        check("t3 valid before 11", 32'(u_if.step_valid), 32'd0);
        tick(1);
        check("t3 valid at 11", 32'(u_if.step_valid), 32'd1);
        check("t3 data", 32'(u_if.step_data), 32'h9);
        tick(20);
        check("t3 single event", 32'(fill), 32'd1);

        // 4: five events into a four-entry FIFO with no consumer
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) settle(pats4[i]);
        check("t4 fill", 32'(fill), 32'd4);
        check("t4 overrun", 32'(overrun), 32'd1);
        check("t4 head", 32'(u_if.step_data), 32'h1);
        check("t4 stable", 32'(stable_data), 32'h5);
        for (int i = 0; i < 4; i++) begin
            check("t4 pop order", 32'(u_if.step_data), 32'(pats4[i]));
            step_ready = 1'b1;
            tick(1);
        end
        step_ready = 1'b0;
        check("t4 drained", 32'(u_if.step_valid), 32'd0);
        step_ready = 1'b1;
        tick(2);
        step_ready = 1'b0;
        check("t4 ready on empty", 32'(fill), 32'd0);

        // 5: commit into a full FIFO on the same edge as a pop
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("t5 overrun cleared", 32'(overrun), 32'd0);
        settle(4'b0110);
        settle(4'b0111);
        settle(4'b1000);
        settle(4'b1010);
        check("t5 full", 32'(fill), 32'd4);
        raw_in = 4'b1011;
        tick(10);
        step_ready = 1'b1;
        tick(1);
        step_ready = 1'b0;
        check("t5 fill kept", 32'(fill), 32'd4);
        check("t5 no overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5 pop order", 32'(u_if.step_data), 32'(exp5[i]));
            step_ready = 1'b1;
            tick(1);
        end
        step_ready = 1'b0;
        check("t5 drained", 32'(u_if.step_valid), 32'd0);

        // 6: reset mid-settle with queued events
        do_reset(4'b0000);
        settle(4'b0011);
        settle(4'b1100);
        check("t6 fill before", 32'(fill), 32'd2);
        raw_in = 4'b1111;
        tick(5);
        reset  = 1'b1;
        raw_in = 4'b0000;
        tick(1);
        check("t6 fill", 32'(fill), 32'd0);
        check("t6 valid", 32'(u_if.step_valid), 32'd0);
        check("t6 overrun", 32'(overrun), 32'd0);
        check("t6 stable", 32'(stable_data), 32'd0);
        reset = 1'b0;
        tick(25);
        check("t6 no abandoned event", 32'(fill), 32'd0);
        check("t6 stable after", 32'(stable_data), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
